timer_display: RTL and testbench
================================

// Module: timer_display
// PURPOSE
//  Downstream of the countdown timer: takes the binary seconds value and the end flags and drives a
//  4-digit multiplexed 7-segment display. Converts binary to BCD with a sequential double-dabble unit,
//  scans the anodes, blinks in the final seconds, and shows "--" on timeout or "LOSE" on a loss.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency
//  REFRESH_HZ    1000         full 4-digit scan rate; per-digit period = CLK_HZ/(REFRESH_HZ*4) cycles
//  BLINK_HZ      2            blink rate in LOW mode; half-period = CLK_HZ/(BLINK_HZ*2) cycles
//  BLINK_THRESH  10           seconds <= this value selects LOW mode
// PORTS
//  clk         in   1  system clock; one clock domain, no other clocks
//  rst         in   1  reset, asynchronous and active-low (asserted when 0)
//  seconds     in   8  binary seconds from the countdown timer, 0..59 nominal
//  score_zero  in   1  sticky timeout flag from the timer
//  lose        in   1  game-lost flag
//  seg         out  7  {g,f,e,d,c,b,a}, active-low
//  dp          out  1  decimal point, active-low; held at 1
//  an          out  4  digit enables, active-low, one-hot; an[0] = rightmost digit
// BEHAVIOUR
//  Reset (async, rst=0): an=4'b1111, seg=7'b1111111, dp=1, scan index=0, prescalers=0, BCD=00,
//   converter=IDLE, blink phase=visible, last_conv=8'hFF (forces a conversion after release).
//  Capture: value v = (seconds>99) ? 99 : seconds. While in IDLE, v != last_conv starts a conversion.
//  Converter FSM: IDLE -> LOAD (latch v, last_conv<=v) -> SHIFT x8 (add-3 on nibbles >=5, then shift)
//   -> COMMIT (tens/ones registers update) -> IDLE. 10 cycles from detection to displayed BCD.
//   Displayed BCD changes only in COMMIT; no partial values are visible.
//  Input change during conversion: current conversion completes, then IDLE detects the mismatch and
//   restarts. The final display always equals the last stable input.
//  Scan: prescaler wraps at per-digit period-1 and advances index 0->1->2->3->0. an/seg are registered
//   and update 1 cycle after the index changes.
//  Mode priority: lose > score_zero > LOW > NORMAL.
//   NORMAL: d3,d2 blank; d1 tens (leading zero shown); d0 ones.
//   LOW: same content as NORMAL; in the hidden blink half an=4'b1111. The blink counter clears on LOW
//    entry, so the first half-period is visible.
//   score_zero: d1,d0 dash (7'b0111111); d3,d2 blank; steady.
//   lose: d3..d0 = L,O,S,E; steady.
//  Segment codes: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//   8=0000000 9=0010000 L=1000111 O=1000000 S=0010010 E=0000110 blank=1111111.
//  Mode changes take effect on the next registered an/seg update. The scan is not restarted.
// STRUCTURE
//  Package display_pkg holds the segment constants, the converter state enum, and the mode enum.
//  One sub-module, bin2bcd_seq: start/busy/done handshake, 8-bit in, {tens,ones} out.
//  The top level holds the change detect, scan prescaler, blink counter, mode mux and output registers.
// TESTING (use CLK_HZ=1000, REFRESH_HZ=50 -> 5 cycles/digit; BLINK_HZ=25 -> 20-cycle half-period)
//  1. rst=0 mid-scan -> an=1111 and seg=1111111 in the same cycle. Release with seconds=59 -> BCD 5,9
//     within 10 cycles; an steps 1110,1101,1011,0111 every 5 cycles; seg=0010000 on d0, 0010010 on d1.
//  2. seconds 59->58 -> d0 shows 9 for exactly 10 cycles, then 0000000. No other value appears.
//  3. seconds=150 -> display 9,9; last_conv=99, with no repeated conversions.
//  4. seconds 45->44->43 on consecutive cycles during a conversion -> displays 45 then 43; 44 is never shown.
//  5. seconds=7 -> 20 cycles of scanning digits, then 20 cycles of an=1111, repeating.
//     seconds=11 -> no blanking.
//  6. score_zero=1 -> d1,d0=0111111 steady. Then lose=1 as well -> L,O,S,E on d3..d0.
//     Then both 0 -> NORMAL restored.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the timer display: segment codes, converter
// states, display modes and the small conversion helpers.
package display_pkg;

    // Segment patterns, {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_LOW,
        MODE_TIMEOUT,
        MODE_LOSE
    } mode_t;

    // Decimal digit to segment pattern; anything above 9 shows blank
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/timer_display_bin2bcd.sv
// Sequential double-dabble converter. start is accepted only while idle;
// the operand is latched in LOAD, eight add-3/shift steps follow, and done
// pulses in COMMIT while tens/ones carry the finished result.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       load,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state;
    conv_state_t state_next;
    // {hundreds, tens, ones, binary}
    logic [19:0] sr;
    logic [19:0] sr_adj;
    logic [2:0]  shift_cnt;

    assign tens = sr[15:12];
    assign ones = sr[11:8];

    // Converter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake strobes
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            CONV_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = CONV_LOAD;
                end
            end
            CONV_LOAD: begin
                load       = 1'b1;
                state_next = CONV_SHIFT;
            end
            CONV_SHIFT: begin
                if (shift_cnt == 3'd7) begin
                    state_next = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                done       = 1'b1;
                state_next = CONV_IDLE;
            end
            default: state_next = CONV_IDLE;
        endcase
    end

    // Add-3 correction of every BCD nibble ahead of the next shift
    always_comb begin
        sr_adj        = sr;
        sr_adj[19:16] = add3(sr[19:16]);
        sr_adj[15:12] = add3(sr[15:12]);
        sr_adj[11:8]  = add3(sr[11:8]);
    end

    // Shift register and step counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr        <= '0;
            shift_cnt <= '0;
        end else begin
            case (state)
                CONV_LOAD: begin
                    sr        <= {12'd0, din};
                    shift_cnt <= '0;
                end
                CONV_SHIFT: begin
                    sr        <= sr_adj << 1;
                    shift_cnt <= shift_cnt + 3'd1;
                end
                default: begin
                    sr        <= sr;
                    shift_cnt <= shift_cnt;
                end
            endcase
        end
    end

endmodule

// File: rtl/timer_display.sv
// 4-digit multiplexed 7-segment driver for the countdown timer. Clamps the
// seconds value, converts it to BCD on change, scans the anodes and picks
// the shown content by mode: lose > timeout > low-time blink > normal.
module timer_display
    import display_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLINK_HZ     = 2,
    parameter int BLINK_THRESH = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seconds,
    input  logic       score_zero,
    input  logic       lose,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int DIGIT_CYC = CLK_HZ / (REFRESH_HZ * 4);
    localparam int HALF_CYC  = CLK_HZ / (BLINK_HZ * 2);
    localparam int PW        = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
    localparam int BW        = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIGIT_CYC - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(HALF_CYC - 1);

    logic [7:0]    v;
    logic [7:0]    last_conv;
    logic          conv_start;
    logic          conv_busy;
    logic          conv_done;
    logic          conv_load;
    logic [3:0]    conv_tens;
    logic [3:0]    conv_ones;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_ones;
    logic [PW-1:0] presc;
    logic [1:0]    scan_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_hidden;
    logic          low_range;
    mode_t         mode;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    // Anything above two digits is shown as 99
    assign v          = (seconds > 8'd99) ? 8'd99 : seconds;
    assign conv_start = !conv_busy && (v != last_conv);
    assign low_range  = (int'(v) <= BLINK_THRESH);
    assign dp         = 1'b1;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .din   (v),
        .busy  (conv_busy),
        .done  (conv_done),
        .load  (conv_load),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    // Remember the operand taken by the converter; the reset value forces a first conversion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_conv <= 8'hFF;
        end else if (conv_load) begin
            last_conv <= v;
        end
    end

    // Displayed digits change only when a conversion commits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_tens <= 4'd0;
            bcd_ones <= 4'd0;
        end else if (conv_done) begin
            bcd_tens <= conv_tens;
            bcd_ones <= conv_ones;
        end
    end

    // Per-digit prescaler and scan index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            scan_idx <= 2'd0;
        end else if (presc == PRESC_MAX) begin
            presc    <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Display mode by priority
    always_comb begin
        if (lose) begin
            mode = MODE_LOSE;
        end else if (score_zero) begin
            mode = MODE_TIMEOUT;
        end else if (low_range) begin
            mode = MODE_LOW;
        end else begin
            mode = MODE_NORMAL;
        end
    end

    // Blink phase runs only in low mode and restarts visible on every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (mode != MODE_LOW) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Content of the digit currently selected by the scan
    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = ~(4'b0001 << scan_idx);
        case (mode)
            MODE_LOSE: begin
                case (scan_idx)
                    2'd3:    seg_next = SEG_L;
                    2'd2:    seg_next = SEG_O;
                    2'd1:    seg_next = SEG_S;
                    default: seg_next = SEG_E;
                endcase
            end
            MODE_TIMEOUT: begin
                if (scan_idx <= 2'd1) begin
                    seg_next = SEG_DASH;
                end
            end
            default: begin
                if (scan_idx == 2'd1) begin
                    seg_next = bcd_to_seg(bcd_tens);
                end else if (scan_idx == 2'd0) begin
                    seg_next = bcd_to_seg(bcd_ones);
                end
                if (mode == MODE_LOW && blink_hidden) begin
                    an_next = 4'b1111;
                end
            end
        endcase
    end

    // Registered anode and segment outputs, dark while in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_timer_display.sv
// Bench for timer_display with a timeline-based reference model plus
// directed scenarios and a randomized input phase.
module tb_timer_display;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic [7:0] seconds    = 8'd0;
    logic       score_zero = 1'b0;
    logic       lose       = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_cmp = 0;
    int n_bad = 0;

    timer_display #(
        .CLK_HZ      (1000),
        .REFRESH_HZ  (50),
        .BLINK_HZ    (25),
        .BLINK_THRESH(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seconds   (seconds),
        .score_zero(score_zero),
        .lose      (lose),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // mode: 3 lose, 2 timeout, 1 low, 0 normal; idx 0 = rightmost digit
    function automatic logic [6:0] content(input int mode, input int idx, input int disp);
        if (mode == 3) begin
            case (idx)
                3: return 7'b1000111;
                2: return 7'b1000000;
                1: return 7'b0010010;
                default: return 7'b0000110;
            endcase
        end else if (mode == 2) begin
            return (idx <= 1) ? 7'b0111111 : 7'b1111111;
        end else if (idx == 1) begin
            return seg_of(disp / 10);
        end else if (idx == 0) begin
            return seg_of(disp % 10);
        end
        return 7'b1111111;
    endfunction

    // Reference model: cycle-indexed timeline since reset release
    int         cyc;
    int         conv_det;
    int         conv_latch;
    int         m_last;
    int         m_disp;
    int         low_start;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_busy;

    initial begin
        int v;
        int idx;
        int mode;
        bit hidden;
        forever begin
            @(posedge clk);
            if (!rst) begin
                cyc       = 0;
                conv_det  = -1;
                m_last    = 255;
                m_disp    = 0;
                low_start = -1;
                exp_an    = 4'hF;
                exp_seg   = 7'h7F;
            end else begin
                v    = (seconds > 99) ? 99 : int'(seconds);
                idx  = (cyc / 5) % 4;
                mode = lose ? 3 : score_zero ? 2 : (v <= 10) ? 1 : 0;
                if (mode == 1) begin
                    if (low_start < 0) low_start = cyc;
                    hidden = (((cyc - low_start) / 20) % 2) == 1;
                end else begin
                    low_start = -1;
                    hidden    = 1'b0;
                end
                exp_an  = hidden ? 4'hF : ~(4'b0001 << idx);
                exp_seg = content(mode, idx, m_disp);
                if (conv_det < 0) begin
                    if (v != m_last) conv_det = cyc;
                end else if (cyc == conv_det + 1) begin
                    conv_latch = v;
                    m_last     = v;
                end else if (cyc == conv_det + 10) begin
                    m_disp   = conv_latch;
                    conv_det = -1;
                end
                cyc++;
            end
            exp_busy = (conv_det >= 0);
            #1;
            check("an", an, exp_an);
            if (exp_an != 4'hF) check("seg", seg, exp_seg);
            check("dp", dp, 1'b1);
            check("last_conv", dut.last_conv, m_last[7:0]);
            check("conv_busy", dut.conv_busy, exp_busy);
        end
    end

    task automatic expect_digit(input string name, input logic [3:0] which, input logic [6:0] exp);
        int k = 0;
        while (an !== which && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (an !== which) check({name, "_timeout"}, an, which);
        else check(name, seg, exp);
    endtask

    task automatic count_dark(input int span, output int dark);
        dark = 0;
        for (int i = 0; i < span; i++) begin
            @(negedge clk);
            if (an == 4'hF) dark++;
        end
    endtask

    initial begin
        int dark;
        int hold;
        int r;
        // Reset state and first scan step
        rst = 1'b0; seconds = 8'd59;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("first_an", an, 4'b1110);
        check("first_seg", seg, 7'b1000000);
        repeat (23) @(negedge clk);
        // Asynchronous reset mid-scan
        #2 rst = 1'b0;
        #1;
        check("async_an", an, 4'hF);
        check("async_seg", seg, 7'h7F);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        expect_digit("d0_9", 4'b1110, 7'b0010000);
        expect_digit("d1_5", 4'b1101, 7'b0010010);
        expect_digit("d2_blank", 4'b1011, 7'b1111111);
        expect_digit("d3_blank", 4'b0111, 7'b1111111);
        // 59 -> 58
        seconds = 8'd58;
        repeat (30) @(negedge clk);
        expect_digit("d0_8", 4'b1110, 7'b0000000);
        // Clamp above 99
        seconds = 8'd150;
        repeat (30) @(negedge clk);
        check("clamp_last", dut.last_conv, 8'd99);
        expect_digit("clamp_d0", 4'b1110, 7'b0010000);
        expect_digit("clamp_d1", 4'b1101, 7'b0010000);
        // Changes during a conversion
        seconds = 8'd45;
        repeat (3) @(negedge clk);
        seconds = 8'd44;
        @(negedge clk);
        seconds = 8'd43;
        repeat (40) @(negedge clk);
        expect_digit("restart_d0", 4'b1110, 7'b0110000);
        expect_digit("restart_d1", 4'b1101, 7'b0011001);
        // Blinking below threshold, none just above it
        seconds = 8'd7;
        repeat (2) @(negedge clk);
        count_dark(80, dark);
        check("blink_dark", dark, 40);
        seconds = 8'd11;
        repeat (2) @(negedge clk);
        count_dark(80, dark);
        check("noblink_dark", dark, 0);
        // Timeout, then lose on top, then back to normal
        score_zero = 1'b1;
        repeat (2) @(negedge clk);
        expect_digit("to_d0", 4'b1110, 7'b0111111);
        expect_digit("to_d1", 4'b1101, 7'b0111111);
        expect_digit("to_d2", 4'b1011, 7'b1111111);
        lose = 1'b1;
        repeat (2) @(negedge clk);
        expect_digit("lose_d3", 4'b0111, 7'b1000111);
        expect_digit("lose_d2", 4'b1011, 7'b1000000);
        expect_digit("lose_d1", 4'b1101, 7'b0010010);
        expect_digit("lose_d0", 4'b1110, 7'b0000110);
        lose = 1'b0; score_zero = 1'b0;
        repeat (2) @(negedge clk);
        expect_digit("back_d0", 4'b1110, 7'b1111001);
        expect_digit("back_d1", 4'b1101, 7'b1111001);
        // Randomized phase
        for (int it = 0; it < 200; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) seconds = 8'($urandom_range(0, 15));
            else if (r < 9) seconds = 8'($urandom_range(0, 120));
            else seconds = 8'hFF;
            score_zero = ($urandom_range(0, 7) == 0);
            lose       = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
            hold = int'($urandom_range(1, 30));
            repeat (hold) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
